// File: rtl/usb3_rx_pkg.sv
// Shared constants and types for the USB 3.0 RX training sequencer.
// Symbol codes, TS identifiers and the lock FSM encoding.
package usb3_rx_pkg;

    localparam logic [7:0]  K_COM    = 8'hBC;
    localparam logic [7:0]  TS1_ID   = 8'h4A;
    localparam logic [7:0]  TS2_ID   = 8'h45;
    localparam logic [31:0] COM_WORD = {4{K_COM}};
    localparam int          LF_DIS_SCR_BIT = 3;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        CHECK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

endpackage

// File: rtl/usb3_ts_parser.sv
// TS1/TS2 ordered-set parser over the 4-symbol word stream.
// Strobes are valid in the cycle the closing word is presented.
module usb3_ts_parser
    import usb3_rx_pkg::*;
(
    input  logic        local_clk,
    input  logic        reset_n,
    input  logic [31:0] in_data,
    input  logic [3:0]  in_datak,
    input  logic        in_active,
    output logic        ts_done,
    output logic        ts_bad,
    output logic [7:0]  ts_type,
    output logic [7:0]  ts_lf
);

    logic [1:0] idx, idx_nxt;
    logic [7:0] id, id_nxt;
    logic [7:0] lf, lf_nxt;
    logic       is_com;
    logic       w1_ok;
    logic       wn_ok;

    assign is_com = (in_data == COM_WORD) && (in_datak == 4'hF);
    assign w1_ok  = (in_datak == 4'h0)
                 && (in_data[31:24] == 8'h00)
                 && (in_data[15:8] == in_data[7:0])
                 && ((in_data[15:8] == TS1_ID) || (in_data[15:8] == TS2_ID));
    assign wn_ok  = (in_datak == 4'h0) && (in_data == {4{id}});

    assign ts_type = id;
    assign ts_lf   = lf;

    always_comb begin
        idx_nxt = idx;
        id_nxt  = id;
        lf_nxt  = lf;
        ts_done = 1'b0;
        ts_bad  = 1'b0;
        if (in_active) begin
            unique case (idx)
                2'd0: begin
                    if (is_com) idx_nxt = 2'd1;
                end
                2'd1: begin
                    if (w1_ok) begin
                        idx_nxt = 2'd2;
                        id_nxt  = in_data[15:8];
                        lf_nxt  = in_data[23:16];
                    end else begin
                        ts_bad = 1'b1;
                    end
                end
                2'd2: begin
                    if (wn_ok) idx_nxt = 2'd3;
                    else       ts_bad  = 1'b1;
                end
                2'd3: begin
                    if (wn_ok) begin
                        idx_nxt = 2'd0;
                        ts_done = 1'b1;
                    end else begin
                        ts_bad = 1'b1;
                    end
                end
            endcase
            // A COM word that breaks a set is taken as the start of the next one
            if (ts_bad) idx_nxt = is_com ? 2'd1 : 2'd0;
        end
    end

    always_ff @(posedge local_clk) begin
        if (!reset_n) begin
            idx <= 2'd0;
            id  <= 8'h00;
            lf  <= 8'h00;
        end else begin
            idx <= idx_nxt;
            id  <= id_nxt;
            lf  <= lf_nxt;
        end
    end

endmodule

// File: rtl/usb3_rx_train_ctrl.sv
// RX training sequencer: ordered-set lock FSM, error accounting
// and descrambler enable for the USB 3.0 receive path.
module usb3_rx_train_ctrl
    import usb3_rx_pkg::*;
#(
    parameter int unsigned LOCK_COUNT = 8,
    parameter int unsigned ERR_LIMIT  = 4,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             local_clk,
    input  logic             reset_n,
    input  logic             scr_allow,
    input  logic [31:0]      in_data,
    input  logic [3:0]       in_datak,
    input  logic             in_active,
    input  logic             in_skp_err,
    output logic             ds_enable,
    output logic             link_lock,
    output logic             rx_ts1,
    output logic             rx_ts2,
    output logic [7:0]       link_func,
    output logic             scr_disabled,
    output logic [CNT_W-1:0] err_count,
    output logic             lock_lost
);

    localparam logic [7:0] LOCK_MAX = LOCK_COUNT[7:0];
    localparam logic [7:0] ERR_MAX  = ERR_LIMIT[7:0];

    logic       ts_done;
    logic       ts_bad;
    logic [7:0] ts_type;
    logic [7:0] ts_lf;
    logic       new_ts2;

    state_t     state, state_nxt;
    logic [7:0] good_cnt, good_nxt;
    logic [7:0] bad_cnt, bad_nxt;
    logic       cur_ts2, type_nxt;
    logic       lost_nxt;

    logic             skp_q;
    logic             skp_rise;
    logic [1:0]       err_inc;
    logic [CNT_W:0]   err_sum;
    logic [CNT_W-1:0] err_nxt;

    usb3_ts_parser u_parser (
        .local_clk (local_clk),
        .reset_n   (reset_n),
        .in_data   (in_data),
        .in_datak  (in_datak),
        .in_active (in_active),
        .ts_done   (ts_done),
        .ts_bad    (ts_bad),
        .ts_type   (ts_type),
        .ts_lf     (ts_lf)
    );

    assign new_ts2   = (ts_type == TS2_ID);
    assign link_lock = (state == LOCKED);

    assign skp_rise = in_skp_err & ~skp_q;
    assign err_inc  = {1'b0, ts_bad} + {1'b0, skp_rise};
    assign err_sum  = {1'b0, err_count} + (CNT_W+1)'(err_inc);
    assign err_nxt  = err_sum[CNT_W] ? '1 : err_sum[CNT_W-1:0];

    always_comb begin
        state_nxt = state;
        good_nxt  = good_cnt;
        bad_nxt   = bad_cnt;
        type_nxt  = cur_ts2;
        lost_nxt  = 1'b0;
        unique case (state)
            HUNT: begin
                if (ts_done) begin
                    good_nxt  = 8'd1;
                    type_nxt  = new_ts2;
                    state_nxt = (LOCK_MAX == 8'd1) ? LOCKED : CHECK;
                end
            end
            CHECK: begin
                if (ts_done) begin
                    if (new_ts2 == cur_ts2) begin
                        if (good_cnt + 8'd1 >= LOCK_MAX) begin
                            good_nxt  = LOCK_MAX;
                            state_nxt = LOCKED;
                        end else begin
                            good_nxt = good_cnt + 8'd1;
                        end
                    end else begin
                        good_nxt = 8'd1;
                        type_nxt = new_ts2;
                    end
                end else if (ts_bad) begin
                    good_nxt  = 8'd0;
                    state_nxt = HUNT;
                end
            end
            LOCKED: begin
                if (ts_done) begin
                    bad_nxt = 8'd0;
                end else if (ts_bad) begin
                    if (bad_cnt + 8'd1 >= ERR_MAX) begin
                        bad_nxt   = 8'd0;
                        good_nxt  = 8'd0;
                        lost_nxt  = 1'b1;
                        state_nxt = HUNT;
                    end else begin
                        bad_nxt = bad_cnt + 8'd1;
                    end
                end
            end
            default: begin
                state_nxt = HUNT;
                good_nxt  = 8'd0;
                bad_nxt   = 8'd0;
            end
        endcase
    end

    always_ff @(posedge local_clk) begin
        if (!reset_n) begin
            state        <= HUNT;
            good_cnt     <= 8'd0;
            bad_cnt      <= 8'd0;
            cur_ts2      <= 1'b0;
            skp_q        <= 1'b0;
            rx_ts1       <= 1'b0;
            rx_ts2       <= 1'b0;
            link_func    <= 8'h00;
            scr_disabled <= 1'b0;
            err_count    <= '0;
            lock_lost    <= 1'b0;
            ds_enable    <= 1'b0;
        end else begin
            state     <= state_nxt;
            good_cnt  <= good_nxt;
            bad_cnt   <= bad_nxt;
            cur_ts2   <= type_nxt;
            skp_q     <= in_skp_err;
            rx_ts1    <= ts_done & ~new_ts2;
            rx_ts2    <= ts_done & new_ts2;
            err_count <= err_nxt;
            lock_lost <= lost_nxt;
            ds_enable <= scr_allow & ~scr_disabled;
            if (ts_done) link_func <= ts_lf;
            if (ts_done && new_ts2) scr_disabled <= ts_lf[LF_DIS_SCR_BIT];
        end
    end

endmodule

// File: tb/tb_usb3_rx_train_ctrl.sv
// Scoreboard bench for usb3_rx_train_ctrl: directed ordered-set
// stimulus queues expected events, a negedge monitor checks them.
module tb_usb3_rx_train_ctrl;

    localparam logic [7:0] T1 = 8'h4A;
    localparam logic [7:0] T2 = 8'h45;

    logic        local_clk = 1'b0;
    logic        reset_n;
    logic        scr_allow;
    logic [31:0] in_data;
    logic [3:0]  in_datak;
    logic        in_active;
    logic        in_skp_err;

    logic        ds_enable, link_lock, rx_ts1, rx_ts2;
    logic [7:0]  link_func;
    logic        scr_disabled, lock_lost;
    logic [15:0] err_count;

    logic        s_ds, s_lock, s_ts1, s_ts2, s_sd, s_lost;
    logic [7:0]  s_lf;
    logic [1:0]  s_err;

    typedef struct {
        logic        ts1;
        logic        ts2;
        logic        lost;
        logic        lock;
        logic [7:0]  lf;
        logic        sd;
        logic [15:0] err;
        logic        ds;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;

    always #5 local_clk = ~local_clk;

    usb3_rx_train_ctrl #(
        .LOCK_COUNT (8),
        .ERR_LIMIT  (4),
        .CNT_W      (16)
    ) u_dut (
        .local_clk    (local_clk),
        .reset_n      (reset_n),
        .scr_allow    (scr_allow),
        .in_data      (in_data),
        .in_datak     (in_datak),
        .in_active    (in_active),
        .in_skp_err   (in_skp_err),
        .ds_enable    (ds_enable),
        .link_lock    (link_lock),
        .rx_ts1       (rx_ts1),
        .rx_ts2       (rx_ts2),
        .link_func    (link_func),
        .scr_disabled (scr_disabled),
        .err_count    (err_count),
        .lock_lost    (lock_lost)
    );

    usb3_rx_train_ctrl #(
        .LOCK_COUNT (8),
        .ERR_LIMIT  (4),
        .CNT_W      (2)
    ) u_sat (
        .local_clk    (local_clk),
        .reset_n      (reset_n),
        .scr_allow    (scr_allow),
        .in_data      (in_data),
        .in_datak     (in_datak),
        .in_active    (in_active),
        .in_skp_err   (in_skp_err),
        .ds_enable    (s_ds),
        .link_lock    (s_lock),
        .rx_ts1       (s_ts1),
        .rx_ts2       (s_ts2),
        .link_func    (s_lf),
        .scr_disabled (s_sd),
        .err_count    (s_err),
        .lock_lost    (s_lost)
    );

    function automatic void check(string name, logic [31:0] act,
                                  logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endfunction

    task automatic push(logic ts1, logic ts2, logic lost, logic lock,
                        logic [7:0] lf, logic sd, logic [15:0] err, logic ds);
        exp_t e;
        e.ts1 = ts1; e.ts2 = ts2; e.lost = lost; e.lock = lock;
        e.lf = lf; e.sd = sd; e.err = err; e.ds = ds;
        q.push_back(e);
    endtask

    task automatic put(logic [31:0] d, logic [3:0] k, logic act);
        in_data   = d;
        in_datak  = k;
        in_active = act;
        @(posedge local_clk);
        #1;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) put(32'h0, 4'h0, 1'b0);
    endtask

    task automatic w0();
        put(32'hBCBCBCBC, 4'hF, 1'b1);
    endtask

    task automatic w1(logic [7:0] id, logic [7:0] lf);
        put({8'h00, lf, id, id}, 4'h0, 1'b1);
    endtask

    task automatic send_set(logic [7:0] id, logic [7:0] lf, logic bad);
        w0();
        idle(1);
        w1(id, lf);
        idle(1);
        put(bad ? {id, 8'h4B, id, id} : {4{id}}, 4'h0, 1'b1);
        put({4{id}}, 4'h0, 1'b1);
        idle(2);
    endtask

    task automatic check_zero(string tag);
        check({tag, "_link_lock"}, 32'(link_lock), 32'h0);
        check({tag, "_ds_enable"}, 32'(ds_enable), 32'h0);
        check({tag, "_rx_ts1"}, 32'(rx_ts1), 32'h0);
        check({tag, "_rx_ts2"}, 32'(rx_ts2), 32'h0);
        check({tag, "_link_func"}, 32'(link_func), 32'h0);
        check({tag, "_scr_disabled"}, 32'(scr_disabled), 32'h0);
        check({tag, "_err_count"}, 32'(err_count), 32'h0);
        check({tag, "_lock_lost"}, 32'(lock_lost), 32'h0);
    endtask

    // Monitor: every pulse or err_count change pops one expected record
    initial begin
        exp_t        e;
        logic [15:0] prev_err = 16'h0;
        logic        ds_pend  = 1'b0;
        logic        ds_exp   = 1'b0;
        forever begin
            @(negedge local_clk);
            if (ds_pend) begin
                check("ds_enable_lag", 32'(ds_enable), 32'(ds_exp));
                ds_pend = 1'b0;
            end
            if (reset_n === 1'b1 &&
                (rx_ts1 || rx_ts2 || lock_lost || err_count != prev_err)) begin
                if (q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_event: ts1=%0b ts2=%0b lost=%0b err=%0h want none",
                             rx_ts1, rx_ts2, lock_lost, err_count);
                end else begin
                    e = q.pop_front();
                    check("rx_ts1", 32'(rx_ts1), 32'(e.ts1));
                    check("rx_ts2", 32'(rx_ts2), 32'(e.ts2));
                    check("lock_lost", 32'(lock_lost), 32'(e.lost));
                    check("link_lock", 32'(link_lock), 32'(e.lock));
                    check("link_func", 32'(link_func), 32'(e.lf));
                    check("scr_disabled", 32'(scr_disabled), 32'(e.sd));
                    check("err_count", 32'(err_count), 32'(e.err));
                    ds_pend = 1'b1;
                    ds_exp  = e.ds;
                end
            end
            prev_err = err_count;
        end
    end

    initial begin
        reset_n    = 1'b0;
        scr_allow  = 1'b1;
        in_skp_err = 1'b0;
        in_data    = 32'h0;
        in_datak   = 4'h0;
        in_active  = 1'b0;
        @(posedge local_clk);
        #1;
        idle(1);
        check_zero("reset");
        check("reset_sat_err", 32'(s_err), 32'h0);
        reset_n = 1'b1;
        idle(2);

        // Eight TS1 sets reach lock on the eighth
        for (int i = 1; i <= 8; i++) begin
            push(1, 0, 0, i == 8, 8'h00, 0, 16'd0, 1);
            send_set(T1, 8'h00, 1'b0);
        end

        // TS2 with Disable-Scrambling set while locked
        for (int i = 1; i <= 3; i++) begin
            push(0, 1, 0, 1, 8'h08, 1, 16'd0, 0);
            send_set(T2, 8'h08, 1'b0);
        end

        // Four corrupt sets drop lock, a fifth only counts
        for (int i = 1; i <= 4; i++) begin
            push(0, 0, i == 4, i < 4, 8'h08, 1, 16'(i), 0);
            send_set(T1, 8'h00, 1'b1);
        end
        push(0, 0, 0, 0, 8'h08, 1, 16'd5, 0);
        send_set(T1, 8'h00, 1'b1);

        // Type switch in CHECK restarts the count
        for (int i = 1; i <= 5; i++) begin
            push(1, 0, 0, 0, 8'h00, 1, 16'd5, 0);
            send_set(T1, 8'h00, 1'b0);
        end
        for (int i = 1; i <= 8; i++) begin
            push(0, 1, 0, i == 8, 8'h00, 0, 16'd5, 1);
            send_set(T2, 8'h00, 1'b0);
        end

        // Truncated set: COM at idx 2 resyncs into a full set
        push(0, 0, 0, 1, 8'h00, 0, 16'd6, 1);
        push(1, 0, 0, 1, 8'h00, 0, 16'd6, 1);
        w0();
        w1(T1, 8'h00);
        w0();
        w1(T1, 8'h00);
        put({4{T1}}, 4'h0, 1'b1);
        put({4{T1}}, 4'h0, 1'b1);
        idle(3);

        // Saturation: SKP rise coincident with a malformed set
        reset_n = 1'b0;
        idle(2);
        reset_n = 1'b1;
        idle(2);
        push(0, 0, 0, 0, 8'h00, 0, 16'd2, 1);
        w0();
        w1(T1, 8'h00);
        in_skp_err = 1'b1;
        put({T1, 8'h4B, T1, T1}, 4'h0, 1'b1);
        put({4{T1}}, 4'h0, 1'b1);
        idle(8);
        in_skp_err = 1'b0;
        idle(2);
        check("sat_err_2", 32'(s_err), 32'd2);
        push(0, 0, 0, 0, 8'h00, 0, 16'd3, 1);
        send_set(T1, 8'h00, 1'b1);
        check("sat_err_3", 32'(s_err), 32'd3);
        push(0, 0, 0, 0, 8'h00, 0, 16'd4, 1);
        send_set(T1, 8'h00, 1'b1);
        check("sat_err_hold", 32'(s_err), 32'd3);
        push(0, 0, 0, 0, 8'h00, 0, 16'd5, 1);
        in_skp_err = 1'b1;
        idle(2);
        in_skp_err = 1'b0;
        idle(2);
        check("sat_err_skp_hold", 32'(s_err), 32'd3);

        // Reset in the middle of a set aborts it silently
        w0();
        w1(T1, 8'h00);
        reset_n = 1'b0;
        put({4{T1}}, 4'h0, 1'b1);
        check_zero("midset");
        idle(1);
        reset_n = 1'b1;
        put({4{T1}}, 4'h0, 1'b1);
        put({4{T1}}, 4'h0, 1'b1);
        idle(3);
        push(1, 0, 0, 0, 8'h00, 0, 16'd0, 1);
        send_set(T1, 8'h00, 1'b0);

        // Descrambler enable follows scr_allow with one cycle of lag
        scr_allow = 1'b0;
        idle(1);
        check("ds_allow_off", 32'(ds_enable), 32'h0);
        scr_allow = 1'b1;
        idle(1);
        check("ds_allow_on", 32'(ds_enable), 32'h1);

        for (int n = 0; n < 50 && q.size() != 0; n++) idle(1);
        if (q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL pending_events: got %0d left want 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
